// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - program memory and PC feeding one instruction at a time to the control unit
// Advances on done, stops after the last instruction or a pending abort, pulses prog_done on exit.
module instr_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [15:0]   wr_data,
  input  logic          start,
  input  logic [AW:0]   prog_len,
  input  logic          abort,
  input  logic          done,
  output logic [15:0]   instruction,
  output logic          run,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          prog_done,
  output logic          aborted
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  state_t        state, state_n;
  logic [15:0]   mem [DEPTH];
  logic [AW:0]   len, len_n;
  logic          abort_pend, abort_pend_n;
  logic [AW-1:0] pc_n, pc_inc;
  logic [15:0]   instruction_n, word0;
  logic          run_n, prog_done_n, aborted_n, is_last;
  logic [AW:0]   eff_len;

  always_ff @(posedge clk) begin
    if (wr_en && state == IDLE)
      mem[wr_addr] <= wr_data;
  end

  // A write to word 0 on the start edge must be visible in the first instruction.
  assign word0   = (wr_en && wr_addr == '0) ? wr_data : mem[0];
  assign eff_len = (prog_len > DEPTH_W) ? DEPTH_W : prog_len;
  assign is_last = ({1'b0, pc} == len - (AW+1)'(1));
  assign pc_inc  = pc + AW'(1);
  assign busy    = (state == RUN);

  always_comb begin
    state_n       = state;
    pc_n          = pc;
    instruction_n = instruction;
    run_n         = run;
    prog_done_n   = 1'b0;
    aborted_n     = aborted;
    len_n         = len;
    abort_pend_n  = abort_pend;
    case (state)
      IDLE: begin
        if (start) begin
          if (eff_len == '0) begin
            prog_done_n = 1'b1;
          end else begin
            state_n       = RUN;
            pc_n          = '0;
            instruction_n = word0;
            run_n         = 1'b1;
            len_n         = eff_len;
            aborted_n     = 1'b0;
            abort_pend_n  = 1'b0;
          end
        end
      end
      RUN: begin
        if (abort)
          abort_pend_n = 1'b1;
        if (done) begin
          if (is_last || abort_pend || abort) begin
            state_n     = IDLE;
            run_n       = 1'b0;
            prog_done_n = 1'b1;
            aborted_n   = ~is_last;
          end else begin
            pc_n          = pc_inc;
            instruction_n = mem[pc_inc];
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= '0;
      instruction <= '0;
      run         <= 1'b0;
      prog_done   <= 1'b0;
      aborted     <= 1'b0;
      len         <= '0;
      abort_pend  <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      instruction <= instruction_n;
      run         <= run_n;
      prog_done   <= prog_done_n;
      aborted     <= aborted_n;
      len         <= len_n;
      abort_pend  <= abort_pend_n;
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - directed self-checking bench for instr_sequencer
// A 4-state control unit model raises done in its last state while run is high.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        reset, wr_en, start, abort, done, done_force;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic [4:0]  prog_len;
  logic [15:0] instruction;
  logic        run, busy, prog_done, aborted;
  logic [3:0]  pc;
  logic [1:0]  cu;
  logic [15:0] inst_log [16];
  int          total = 0;
  int          bad = 0;
  int          rc, dk;

  instr_sequencer #(.DEPTH(16), .AW(4)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .prog_len(prog_len), .abort(abort), .done(done),
    .instruction(instruction), .run(run), .pc(pc), .busy(busy),
    .prog_done(prog_done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset || !run) cu <= 2'd0;
    else               cu <= cu + 2'd1;
  end
  assign done = (run && cu == 2'd3) || done_force;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic go(input logic [4:0] n);
    start = 1'b1; prog_len = n;
    step();
    start = 1'b0;
  endtask

  // Counts run cycles until prog_done appears; dk is the cycle offset of the pulse (-1 if never).
  task automatic observe(output int rcnt, output int dkk);
    rcnt = 0; dkk = -1;
    for (int i = 0; i < 16; i++) inst_log[i] = 16'h0;
    for (int k = 0; k < 200; k++) begin
      if (run) begin
        rcnt++;
        inst_log[pc] = instruction;
      end
      if (prog_done) begin
        dkk = k;
        break;
      end
      step();
    end
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
    prog_len = '0; abort = 1'b0; done_force = 1'b0;
    repeat (3) step();
    chk("rst_instr", instruction, 16'h0);
    chk("rst_run", run, 1'b0);
    chk("rst_pc", pc, 4'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_pdone", prog_done, 1'b0);
    chk("rst_aborted", aborted, 1'b0);
    reset = 1'b0;
    step();

    wr(4'd0, 16'h2004); wr(4'd1, 16'h4408); wr(4'd2, 16'h6C10);
    go(5'd3);
    chk("t1_first", instruction, 16'h2004);
    chk("t1_busy", busy, 1'b1);
    observe(rc, dk);
    chk("t1_runcyc", rc, 12);
    chk("t1_dk", dk, 12);
    chk("t1_i0", inst_log[0], 16'h2004);
    chk("t1_i1", inst_log[1], 16'h4408);
    chk("t1_i2", inst_log[2], 16'h6C10);
    chk("t1_pc", pc, 4'd2);
    chk("t1_hold", instruction, 16'h6C10);
    chk("t1_aborted", aborted, 1'b0);
    step();
    chk("t1_pd_low", prog_done, 1'b0);
    chk("t1_idle", busy, 1'b0);

    go(5'd0);
    chk("t2_run", run, 1'b0);
    chk("t2_pdone", prog_done, 1'b1);
    chk("t2_busy", busy, 1'b0);
    step();
    chk("t2_pd_low", prog_done, 1'b0);

    for (int i = 3; i < 16; i++) wr(4'(i), 16'h1000 + 16'(i));
    go(5'd20);
    observe(rc, dk);
    chk("t3_runcyc", rc, 64);
    chk("t3_dk", dk, 64);
    chk("t3_pc", pc, 4'd15);
    chk("t3_i15", inst_log[15], 16'h100F);
    chk("t3_i7", inst_log[7], 16'h1007);
    step();

    go(5'd5);
    repeat (5) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t4_pc_mid", pc, 4'd1);
    chk("t4_run_mid", run, 1'b1);
    observe(rc, dk);
    chk("t4_dk", dk, 2);
    chk("t4_pc", pc, 4'd1);
    chk("t4_aborted", aborted, 1'b1);
    chk("t4_run", run, 1'b0);
    step();
    chk("t4_pd_low", prog_done, 1'b0);
    chk("t4_ab_hold", aborted, 1'b1);

    go(5'd1);
    chk("t5_ab_clr", aborted, 1'b0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    observe(rc, dk);
    chk("t5_dk", dk, 3);
    chk("t5_aborted", aborted, 1'b0);
    chk("t5_pc", pc, 4'd0);
    step();

    go(5'd2);
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF; start = 1'b1; prog_len = 5'd1;
    step();
    wr_en = 1'b0; start = 1'b0;
    chk("t6_pc", pc, 4'd0);
    chk("t6_instr", instruction, 16'h2004);
    observe(rc, dk);
    chk("t6_dk", dk, 7);
    chk("t6_pc_end", pc, 4'd1);
    step();
    done_force = 1'b1;
    step();
    done_force = 1'b0;
    chk("idle_done_run", run, 1'b0);
    chk("idle_done_pc", pc, 4'd1);
    chk("idle_done_pd", prog_done, 1'b0);
    go(5'd1);
    chk("t6_rerun", instruction, 16'h2004);
    observe(rc, dk);
    chk("t6_rerun_dk", dk, 4);
    step();

    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hABCD; start = 1'b1; prog_len = 5'd1;
    step();
    wr_en = 1'b0; start = 1'b0;
    chk("byp_instr", instruction, 16'hABCD);
    observe(rc, dk);
    chk("byp_dk", dk, 4);
    step();
    wr(4'd0, 16'h2004);

    go(5'd3);
    repeat (8) step();
    chk("t7_pc_mid", pc, 4'd2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t7_run", run, 1'b0);
    chk("t7_pc", pc, 4'd0);
    chk("t7_instr", instruction, 16'h0);
    chk("t7_busy", busy, 1'b0);
    step();
    go(5'd3);
    observe(rc, dk);
    chk("t7_dk", dk, 12);
    chk("t7_i0", inst_log[0], 16'h2004);
    chk("t7_i1", inst_log[1], 16'h4408);
    chk("t7_i2", inst_log[2], 16'h6C10);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
